labft_n: RTL

- Parametrised checksum-based fault detector for an arraySize x arraySize output-stationary systolic tile.
- Tile computation: C = sum over tileLen beats of a_k * b_k^T.
- Block predicts per-column checksums from the input streams, sums the drained output rows, and flags mismatched columns.
- Sits beside the array on the same input/output buses; one-deep pending buffer lets tile t+1 inputs overlap tile t output drain.

---
 rtl/labft_n.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/labft_n.sv
// labft_n: checksum-based fault detector for an arraySize x arraySize
// output-stationary systolic tile.
//
// While the array consumes a tile's input beats, this block predicts the
// column sums of the tile result C = sum_k a_k * b_k^T. When the array
// drains its output rows, the block sums them per column and compares the
// sums with the prediction. The prediction waits in a one-deep pending
// buffer, so the inputs of tile t+1 can stream in while tile t drains.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   validInputs    a/b beat valid
//   a, b           input lanes, lane i at [i*inputBits +: inputBits]
//   validOutputs   one output row valid
//   c_row          output row, element j at [j*outputBits +: outputBits]
//   errorValid     one-cycle pulse when a tile check completes
//   error          per-column mismatch, held until the next errorValid
//   errorAny       OR of error, held likewise
//   errorCount     number of faulty tiles, saturating
//   overrun        sticky: a tile checksum was dropped
//   protoErr       sticky: rows drained with no pending checksum, or a row
//                  arrived during the check cycle
//   busy           input tile in progress, checksum pending, or check active
module labft_n #(
   parameter int arraySize  = 4,
   parameter int inputBits  = 8,
   parameter int outputBits = 32,
   parameter int tileLen    = 16,
   parameter int countBits  = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             validInputs,
   input  logic [arraySize*inputBits-1:0]   a,
   input  logic [arraySize*inputBits-1:0]   b,
   input  logic                             validOutputs,
   input  logic [arraySize*outputBits-1:0]  c_row,
   output logic                             errorValid,
   output logic [arraySize-1:0]             error,
   output logic                             errorAny,
   output logic [countBits-1:0]             errorCount,
   output logic                             overrun,
   output logic                             protoErr,
   output logic                             busy
);

   localparam int SW = inputBits + $clog2(arraySize);
   localparam int BW = (tileLen > 1) ? $clog2(tileLen) : 1;
   localparam int RW = (arraySize > 1) ? $clog2(arraySize) : 1;

   typedef enum logic [1:0] {O_IDLE, O_ACC, O_CHECK} out_state_t;

   logic [SW-1:0]                          s_a;
   logic [arraySize-1:0][outputBits-1:0]   pred;
   logic [arraySize-1:0][outputBits-1:0]   pred_next;
   logic [arraySize-1:0][outputBits-1:0]   pend;
   logic [arraySize-1:0][outputBits-1:0]   act;
   logic [arraySize-1:0][outputBits-1:0]   act_next;
   logic [arraySize-1:0]                   mismatch;
   logic [BW-1:0]                          beat_cnt;
   logic [RW-1:0]                          row_cnt;
   logic                                   pend_valid;
   logic                                   tile_done;
   logic                                   consume;
   out_state_t                             state;

   // Column j of C summed over all rows equals (sum_i a[i]) * b[j] summed
   // over beats, so one lane sum per beat is enough for every column.
   // Everything is kept modulo 2^outputBits, the same wrap the array has.
   always_comb begin
      s_a = '0;
      for (int i = 0; i < arraySize; i++) begin
         s_a = s_a + SW'(a[i*inputBits +: inputBits]);
      end
      for (int j = 0; j < arraySize; j++) begin
         pred_next[j] = pred[j] + outputBits'(s_a) * outputBits'(b[j*inputBits +: inputBits]);
         act_next[j]  = act[j] + c_row[j*outputBits +: outputBits];
         mismatch[j]  = (act[j] != pend[j]);
      end
   end

   assign tile_done = validInputs && (beat_cnt == BW'(tileLen - 1));
   assign consume   = (state == O_CHECK) && pend_valid;
   assign busy      = (beat_cnt != '0) || pend_valid || (state != O_IDLE);

   // Input-side accumulation; the last beat of a tile restarts the
   // accumulators on the same edge its total is handed to the pending buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pred     <= '0;
         beat_cnt <= '0;
      end else if (validInputs) begin
         if (tile_done) begin
            pred     <= '0;
            beat_cnt <= '0;
         end else begin
            pred     <= pred_next;
            beat_cnt <= beat_cnt + BW'(1);
         end
      end
   end

   // Pending buffer. A checksum being consumed by the check on the same
   // edge frees the slot, so a completing tile may take it without overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend       <= '0;
         pend_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (tile_done) begin
         if (!pend_valid || consume) begin
            pend       <= pred_next;
            pend_valid <= 1'b1;
         end else begin
            overrun <= 1'b1;
         end
      end else if (consume) begin
         pend_valid <= 1'b0;
      end
   end

   // Output-side FSM. The first row is accumulated on the edge that leaves
   // O_IDLE so N rows lead straight to the single O_CHECK cycle; the result
   // registers update on the edge leaving O_CHECK.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= O_IDLE;
         row_cnt    <= '0;
         act        <= '0;
         error      <= '0;
         errorAny   <= 1'b0;
         errorValid <= 1'b0;
         errorCount <= '0;
         protoErr   <= 1'b0;
      end else begin
         errorValid <= 1'b0;
         case (state)
            O_IDLE, O_ACC: begin
               if (validOutputs) begin
                  act <= act_next;
                  if (row_cnt == RW'(arraySize - 1)) begin
                     row_cnt <= '0;
                     state   <= O_CHECK;
                  end else begin
                     row_cnt <= row_cnt + RW'(1);
                     state   <= O_ACC;
                  end
               end
            end
            O_CHECK: begin
               if (pend_valid) begin
                  error      <= mismatch;
                  errorAny   <= |mismatch;
                  errorValid <= 1'b1;
                  if ((|mismatch) && (errorCount != '1)) begin
                     errorCount <= errorCount + countBits'(1);
                  end
               end else begin
                  protoErr <= 1'b1;
               end
               if (validOutputs) begin
                  protoErr <= 1'b1;
               end
               act   <= '0;
               state <= O_IDLE;
            end
            default: begin
               state <= O_IDLE;
            end
         endcase
      end
   end

endmodule
